// File: rtl/cache_mem_arbiter_pkg.sv
// ============================================================================
// cache_mem_arbiter_pkg : shared types and constants for the memory-port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_BEATS  = 8;

  // Dense 2-bit encoding keeps the state register and the decode narrow.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_I_FILL  = 2'd1,
    ARB_D_FILL  = 2'd2,
    ARB_D_WRITE = 2'd3
  } arb_state_e;

  function automatic logic arb_is_fill(input arb_state_e s);
    return (s == ARB_I_FILL) || (s == ARB_D_FILL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter_arb_beat_counter.sv
// ============================================================================
// arb_beat_counter : counts returned fill beats, flags the final beat of a block
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_beat_counter #(
  parameter int BEATS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] C_TERM = CW'(BEATS - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count_q == C_TERM) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == C_TERM);

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter : shares one memory port between I-cache/D-cache fills and
// D-cache write-through stores. Optional macro: CACHE_ARB_ROUND_ROBIN_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int BEATS = ARB_BEATS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_req,
  input  logic [ARB_ADDR_W-1:0] icache_addr,
  input  logic                  icache_mem_en,
  input  logic                  dcache_req,
  input  logic                  dcache_wr,
  input  logic [ARB_ADDR_W-1:0] dcache_addr,
  input  logic                  dcache_mem_en,
  input  logic                  mem_data_valid,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ARB_ADDR_W-1:0] mem_addr,
  output logic                  icache_grant,
  output logic                  dcache_grant,
  output logic                  icache_data_valid,
  output logic                  dcache_data_valid
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       in_fill;
  logic       beat_inc;
  logic       beat_last;
  logic       fill_done;
  logic       pick_d;

  assign in_fill   = arb_is_fill(state_q);
  assign beat_inc  = in_fill & mem_data_valid;
  assign fill_done = beat_inc & beat_last;

  arb_beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (~in_fill),
    .inc   (beat_inc),
    .last  (beat_last)
  );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 0 = I-cache served last, 1 = D-cache served last; updated as a grant ends.
  logic last_served_q;
  logic last_served_d;

  always_comb begin
    last_served_d = last_served_q;
    if (state_q == ARB_I_FILL && fill_done) begin
      last_served_d = 1'b0;
    end else if ((state_q == ARB_D_FILL && fill_done) || state_q == ARB_D_WRITE) begin
      last_served_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served_q <= 1'b0;
    end else begin
      last_served_q <= last_served_d;
    end
  end

  assign pick_d = ~last_served_q;
`else
  assign pick_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (dcache_req && (!icache_req || pick_d)) begin
          state_d = dcache_wr ? ARB_D_WRITE : ARB_D_FILL;
        end else if (icache_req) begin
          state_d = ARB_I_FILL;
        end
      end
      ARB_I_FILL, ARB_D_FILL: begin
        if (fill_done) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_D_WRITE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign icache_grant = (state_q == ARB_I_FILL);
  assign dcache_grant = (state_q == ARB_D_FILL) || (state_q == ARB_D_WRITE);

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    case (state_q)
      ARB_I_FILL: begin
        mem_enable = icache_mem_en;
        mem_addr   = icache_addr;
      end
      ARB_D_FILL: begin
        mem_enable = dcache_mem_en;
        mem_addr   = dcache_addr;
      end
      ARB_D_WRITE: begin
        mem_enable = dcache_mem_en;
        mem_wr     = 1'b1;
        mem_addr   = dcache_addr;
      end
      default: ;
    endcase
  end

  assign icache_data_valid = mem_data_valid & (state_q == ARB_I_FILL);
  assign dcache_data_valid = mem_data_valid & (state_q == ARB_D_FILL);

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// tb_cache_mem_arbiter : directed scoreboard bench for cache_mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req, icache_mem_en, dcache_req, dcache_wr, dcache_mem_en;
  logic [15:0] icache_addr, dcache_addr;
  logic        mem_data_valid;
  logic        mem_enable, mem_wr, icache_grant, dcache_grant;
  logic        icache_data_valid, dcache_data_valid;
  logic [15:0] mem_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit is_d;
    int beats;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .icache_mem_en     (icache_mem_en),
    .dcache_req        (dcache_req),
    .dcache_wr         (dcache_wr),
    .dcache_addr       (dcache_addr),
    .dcache_mem_en     (dcache_mem_en),
    .mem_data_valid    (mem_data_valid),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .mem_addr          (mem_addr),
    .icache_grant      (icache_grant),
    .dcache_grant      (dcache_grant),
    .icache_data_valid (icache_data_valid),
    .dcache_data_valid (dcache_data_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant monitor: each grant episode pops one expected owner/beat-count entry.
  bit   mon_active = 1'b0;
  bit   mon_is_d;
  int   mon_beats;
  int   mon_exp_beats;
  exp_t mon_e;

  always @(negedge clk) begin
    chk("grant_onehot", 32'(icache_grant & dcache_grant), 0);
    if (mon_active && (icache_grant || dcache_grant) && (dcache_grant != mon_is_d)) begin
      chk("grant_switch_without_idle", 32'(dcache_grant), 32'(mon_is_d));
    end
    if (!mon_active && (icache_grant || dcache_grant)) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", 1, 0);
        mon_exp_beats = 0;
      end else begin
        mon_e = sb.pop_front();
        chk("grant_owner", 32'(dcache_grant), 32'(mon_e.is_d));
        mon_exp_beats = mon_e.beats;
      end
      mon_active = 1'b1;
      mon_is_d   = dcache_grant;
      mon_beats  = 0;
    end else if (mon_active && !icache_grant && !dcache_grant) begin
      chk("episode_beats", 32'(mon_beats), 32'(mon_exp_beats));
      mon_active = 1'b0;
    end
    if (mon_active && (icache_data_valid || dcache_data_valid)) mon_beats++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n valid beats; requester drops its req on beat index drop_at.
  task automatic run_beats(input bit is_d, input int n, input int drop_at);
    for (int b = 0; b < n; b++) begin
      step();
      mem_data_valid = 1'b1;
      if (is_d) dcache_addr = dcache_addr + 16'd2;
      else      icache_addr = icache_addr + 16'd2;
      if (b == drop_at) begin
        if (is_d) dcache_req = 1'b0;
        else      icache_req = 1'b0;
      end
      @(negedge clk);
      chk("dv_owner", 32'(is_d ? dcache_data_valid : icache_data_valid), 1);
      chk("dv_other", 32'(is_d ? icache_data_valid : dcache_data_valid), 0);
      chk("grant_held", 32'(is_d ? dcache_grant : icache_grant), 1);
      chk("mem_addr_fill", 32'(mem_addr), 32'(is_d ? dcache_addr : icache_addr));
    end
    step();
    mem_data_valid = 1'b0;
    @(negedge clk);
    chk("grant_dropped", 32'({icache_grant, dcache_grant}), 0);
    chk("idle_mem_enable", 32'(mem_enable), 0);
    chk("idle_mem_addr", 32'(mem_addr), 0);
  endtask

  task automatic push(input bit is_d, input int beats);
    exp_t e;
    e.is_d  = is_d;
    e.beats = beats;
    sb.push_back(e);
  endtask

  task automatic check_grant(input bit is_d);
    @(negedge clk);
    chk("grant_rise", 32'(is_d ? dcache_grant : icache_grant), 1);
    chk("mem_enable_rise", 32'(mem_enable), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    icache_req = 0; icache_mem_en = 1; icache_addr = 16'h0100;
    dcache_req = 0; dcache_wr = 0; dcache_mem_en = 1; dcache_addr = 16'h1000;
    mem_data_valid = 0;
    step();
    @(negedge clk);
    chk("rst_grants", 32'({icache_grant, dcache_grant}), 0);
    chk("rst_mem", 32'({mem_enable, mem_wr, mem_addr}), 0);
    step();
    rst_n = 1'b1;

    // Single I-cache miss with memory latency before the first beat.
    step();
    icache_req = 1'b1; icache_addr = 16'h0100;
    push(1'b0, 8);
    @(negedge clk);
    chk("grant_not_early", 32'(icache_grant), 0);
    step();
    check_grant(1'b0);
    chk("i_first_addr", 32'(mem_addr), 32'h0100);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("latency_no_dv", 32'({icache_data_valid, dcache_data_valid}), 0);
    end
    icache_addr = 16'h00FE;
    run_beats(1'b0, 8, 7);

    // Tie: D-cache first in either configuration (I-cache served last), then I-cache.
    step();
    icache_req = 1; dcache_req = 1; dcache_wr = 0;
    push(1'b1, 8); push(1'b0, 8);
    step();
    check_grant(1'b1);
    run_beats(1'b1, 8, 7);
    step();
    check_grant(1'b0);
    run_beats(1'b0, 8, 7);

    // Single-word D-cache store; a stray valid beat must not be routed.
    step();
    dcache_req = 1; dcache_wr = 1; dcache_addr = 16'h2004;
    push(1'b1, 0);
    step();
    dcache_req = 0; mem_data_valid = 1;
    @(negedge clk);
    chk("store_enable", 32'(mem_enable), 1);
    chk("store_wr", 32'(mem_wr), 1);
    chk("store_addr", 32'(mem_addr), 32'h2004);
    chk("store_no_dv", 32'(dcache_data_valid), 0);
    step();
    mem_data_valid = 0;
    @(negedge clk);
    chk("store_one_cycle", 32'({mem_wr, dcache_grant}), 0);

    // Spurious valid in IDLE.
    step();
    mem_data_valid = 1;
    @(negedge clk);
    chk("idle_spurious_dv", 32'({icache_data_valid, dcache_data_valid}), 0);
    step();
    mem_data_valid = 0;

    // Tie after a D-cache store: round robin favours I-cache, fixed priority D-cache.
    icache_req = 1; dcache_req = 1; dcache_wr = 0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    push(1'b0, 8); push(1'b1, 8);
    step(); check_grant(1'b0); run_beats(1'b0, 8, 7);
    step(); check_grant(1'b1); run_beats(1'b1, 8, 7);
`else
    push(1'b1, 8); push(1'b0, 8);
    step(); check_grant(1'b1); run_beats(1'b1, 8, 7);
    step(); check_grant(1'b0); run_beats(1'b0, 8, 7);
`endif

    // Asynchronous reset after beat 5 of a D fill.
    step();
    dcache_req = 1; dcache_wr = 0;
    push(1'b1, 5);
    step();
    check_grant(1'b1);
    for (int b = 0; b < 5; b++) begin
      step();
      mem_data_valid = 1;
      @(negedge clk);
      chk("pre_reset_dv", 32'(dcache_data_valid), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'({icache_grant, dcache_grant}), 0);
    chk("async_rst_mem", 32'({mem_enable, mem_wr, mem_addr}), 0);
    chk("async_rst_dv", 32'({icache_data_valid, dcache_data_valid}), 0);
    dcache_req = 0; mem_data_valid = 0;
    step();
    step();
    rst_n = 1'b1;

    // Fresh fill after reset counts all 8 beats; req dropped after beat 3
    // while a D store waits and must not be granted early.
    step();
    icache_req = 1;
    push(1'b0, 8); push(1'b1, 0);
    step();
    check_grant(1'b0);
    dcache_req = 1; dcache_wr = 1; dcache_addr = 16'h3000;
    run_beats(1'b0, 8, 3);
    step();
    dcache_req = 0;
    @(negedge clk);
    chk("waiting_store_grant", 32'(dcache_grant), 1);
    chk("waiting_store_wr", 32'(mem_wr), 1);
    step();
    @(negedge clk);
    chk("final_idle", 32'({icache_grant, dcache_grant}), 0);

    step();
    step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    chk("monitor_closed", 32'(mon_active), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
